// File: rtl/poly_stream_bridge_pkg.sv
// rtl/poly_stream_bridge_pkg.sv - shared encodings for the polynomial stream bridge
package poly_stream_bridge_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_RING_SIZE = 256;

  typedef enum logic [2:0] {
    MODE_LOAD_W = 3'd0,
    MODE_LOAD_A = 3'd1,
    MODE_LOAD_B = 3'd2,
    MODE_GO     = 3'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FILL, ST_DISCARD, ST_START, ST_WAIT_BUSY, ST_RUN, ST_DRAIN
  } state_e;

  localparam int ERR_MODE = 0;
  localparam int ERR_OVF  = 1;
  localparam int ERR_LEN  = 2;

endpackage

// File: rtl/poly_stream_bridge_if.sv
// rtl/poly_stream_bridge_if.sv - host stream and multiplier-side signals of the bridge
interface poly_stream_bridge_if
  import poly_stream_bridge_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              s_valid, s_ready, s_last;
  logic [DATA_W-1:0] s_data;
  logic              m_valid, m_ready, m_last;
  logic [DATA_W-1:0] m_data;
  logic              pm_start;
  logic [2:0]        pm_mode;
  logic              pm_busy, pm_done_all;
  logic              pm_valid_in, pm_rd_enable;
  logic [DATA_W-1:0] pm_din;
  logic              pm_valid_out, pm_wr_enable;
  logic [DATA_W-1:0] pm_dout;
  logic              pm_fifo_full;

  modport slave (
    input  s_valid, s_data, s_last, m_ready, pm_busy, pm_done_all,
           pm_rd_enable, pm_valid_out, pm_wr_enable, pm_dout,
    output s_ready, m_valid, m_data, m_last, pm_start, pm_mode,
           pm_valid_in, pm_din, pm_fifo_full
  );

  modport master (
    output s_valid, s_data, s_last, m_ready, pm_busy, pm_done_all,
           pm_rd_enable, pm_valid_out, pm_wr_enable, pm_dout,
    input  s_ready, m_valid, m_data, m_last, pm_start, pm_mode,
           pm_valid_in, pm_din, pm_fifo_full
  );
endinterface

// File: rtl/poly_stream_bridge_fifo.sv
// rtl/poly_stream_bridge_fifo.sv - sync_fifo_fwft: first-word-fall-through buffer
// Head reads as zero while empty so idle data outputs stay quiet.
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign occupancy = wr_ptr - rd_ptr;
  assign empty     = (occupancy == '0);
  assign full      = (occupancy == FULL_OCC);
  assign do_pop    = pop && !empty;
  // a same-cycle pop frees the slot the push lands in
  assign do_push   = push && (!full || do_pop);
  assign rdata     = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/poly_stream_bridge.sv
// rtl/poly_stream_bridge.sv - frames host commands into the multiplier and streams results back
// Optional POLY_BRIDGE_LEN_CHECK_EN rejects load A/B payloads whose length differs from RING_SIZE.
module poly_stream_bridge
  import poly_stream_bridge_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RING_SIZE = DEF_RING_SIZE,
  parameter int IN_DEPTH  = 512,
  parameter int OUT_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  poly_stream_bridge_if.slave  bus,
  output logic                 frame_done,
  output logic [2:0]           err
);
  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam int CNT_W  = $clog2(RING_SIZE) + 1;
  localparam logic [OUT_AW:0]  OUT_ALMOST = (OUT_AW+1)'(OUT_DEPTH - 2);
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(RING_SIZE - 1);

  state_e            state;
  logic [2:0]        mode_q;
  logic              s_ready_q, pm_start_q;
  logic              s_hs, m_hs, len_bad;
  logic              in_push, in_clr, in_empty, in_full, in_ovf;
  logic              out_push, out_empty, out_full, out_ovf;
  logic [IN_AW:0]    in_occ;
  logic [OUT_AW:0]   out_occ;
  logic [CNT_W-1:0]  pop_cnt;

  assign s_hs     = bus.s_valid && s_ready_q;
  assign m_hs     = bus.m_valid && bus.m_ready;
  assign in_push  = (state == ST_FILL) && s_hs;
  assign in_ovf   = in_push && in_full && !bus.pm_rd_enable;
  assign out_push = bus.pm_wr_enable && bus.pm_valid_out;
  assign out_ovf  = out_push && out_full && !m_hs;
  assign in_clr   = in_push && bus.s_last && len_bad;

  assign bus.s_ready      = s_ready_q;
  assign bus.pm_start     = pm_start_q;
  assign bus.pm_mode      = mode_q;
  assign bus.pm_valid_in  = (in_occ != '0);
  assign bus.m_valid      = !out_empty;
  // two-slot margin covers the multiplier's registered write enable
  assign bus.pm_fifo_full = (out_occ >= OUT_ALMOST);
  assign bus.m_last       = bus.m_valid && (mode_q == MODE_GO) && (pop_cnt == LAST_IDX);

`ifdef POLY_BRIDGE_LEN_CHECK_EN
  localparam logic [15:0] RING_LEN = 16'(RING_SIZE);
  logic [15:0] len_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 len_q <= '0;
    else if (state == ST_IDLE) len_q <= '0;
    else if (in_push)          len_q <= len_q + 16'd1;
  end

  assign len_bad = ((mode_q == MODE_LOAD_A) || (mode_q == MODE_LOAD_B)) &&
                   ((len_q + 16'd1) != RING_LEN);
`else
  assign len_bad = 1'b0;
`endif

  sync_fifo_fwft #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk(clk), .reset(reset), .clr(in_clr), .push(in_push), .wdata(bus.s_data),
    .pop(bus.pm_rd_enable), .rdata(bus.pm_din), .empty(in_empty), .full(in_full),
    .occupancy(in_occ)
  );

  sync_fifo_fwft #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk(clk), .reset(reset), .clr(1'b0), .push(out_push), .wdata(bus.pm_dout),
    .pop(m_hs), .rdata(bus.m_data), .empty(out_empty), .full(out_full),
    .occupancy(out_occ)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           pop_cnt <= '0;
    else if (m_hs && (mode_q == MODE_GO)) pop_cnt <= bus.m_last ? '0 : pop_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      mode_q     <= '0;
      s_ready_q  <= 1'b0;
      pm_start_q <= 1'b0;
      frame_done <= 1'b0;
      err        <= '0;
    end else begin
      pm_start_q <= 1'b0;
      frame_done <= 1'b0;
      if (in_ovf || out_ovf) err[ERR_OVF] <= 1'b1;
      case (state)
        ST_IDLE: begin
          s_ready_q <= 1'b1;
          if (s_hs) begin
            mode_q <= bus.s_data[2:0];
            if (bus.s_data[2:0] > MODE_GO) begin
              err[ERR_MODE] <= 1'b1;
              if (!bus.s_last) state <= ST_DISCARD;
            end else if (!bus.s_last) begin
              state <= ST_FILL;
            end else if (bus.s_data[2:0] == MODE_GO) begin
              state      <= ST_START;
              pm_start_q <= 1'b1;
              s_ready_q  <= 1'b0;
            end else begin
              err[ERR_LEN] <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (s_hs && bus.s_last) begin
            if (len_bad) begin
              err[ERR_LEN] <= 1'b1;
              state        <= ST_IDLE;
            end else begin
              state      <= ST_START;
              pm_start_q <= 1'b1;
              s_ready_q  <= 1'b0;
            end
          end
        end
        ST_DISCARD:   if (s_hs && bus.s_last) state <= ST_IDLE;
        ST_START:     state <= ST_WAIT_BUSY;
        ST_WAIT_BUSY: if (bus.pm_busy) state <= ST_RUN;
        ST_RUN: begin
          if (mode_q == MODE_GO) begin
            if (bus.pm_done_all) state <= ST_DRAIN;
          end else if (in_empty && !bus.pm_busy) begin
            frame_done <= 1'b1;
            s_ready_q  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (m_hs && bus.m_last) begin
            frame_done <= 1'b1;
            s_ready_q  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_poly_stream_bridge.sv
// tb/tb_poly_stream_bridge.sv - randomized self-checking bench for poly_stream_bridge
module tb_poly_stream_bridge;
  localparam int DW   = 16;
  localparam int RS   = 256;
  localparam int IND  = 256;
  localparam int OUTD = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_done;
  logic [2:0] err;

  poly_stream_bridge_if #(.DATA_W(DW)) bus ();

  poly_stream_bridge #(.DATA_W(DW), .RING_SIZE(RS), .IN_DEPTH(IND), .OUT_DEPTH(OUTD)) dut (
    .clk(clk), .reset(reset), .bus(bus), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  int done_cnt  = 0;

  always @(posedge clk) begin
    if (bus.pm_start) start_cnt++;
    if (frame_done)   done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"},      32'(bus.s_ready),      32'd0);
    check({tag, "_m_valid"},      32'(bus.m_valid),      32'd0);
    check({tag, "_m_last"},       32'(bus.m_last),       32'd0);
    check({tag, "_pm_start"},     32'(bus.pm_start),     32'd0);
    check({tag, "_pm_valid_in"},  32'(bus.pm_valid_in),  32'd0);
    check({tag, "_frame_done"},   32'(frame_done),       32'd0);
    check({tag, "_err"},          32'(err),              32'd0);
    check({tag, "_pm_mode"},      32'(bus.pm_mode),      32'd0);
    check({tag, "_m_data"},       32'(bus.m_data),       32'd0);
    check({tag, "_pm_din"},       32'(bus.pm_din),       32'd0);
    check({tag, "_pm_fifo_full"}, 32'(bus.pm_fifo_full), 32'd0);
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic last);
    int   t;
    logic acc;
    repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    t = 0;
    do begin
      @(negedge clk);
      acc = bus.s_ready;
      @(posedge clk); #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) check("s_accept_timeout", 32'd0, 32'd1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] hdr, input logic [DW-1:0] pay[$]);
    push_word(hdr, pay.size() == 0);
    for (int i = 0; i < pay.size(); i++) push_word(pay[i], i == pay.size() - 1);
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 100) begin @(posedge clk); #1; t++; end
    repeat (2) begin @(posedge clk); #1; end
    check("frame_done_cnt", 32'(done_cnt), 32'(target));
  endtask

  // multiplier consuming a load frame; exp_q holds the words the bridge should present
  task automatic run_load(input logic [DW-1:0] exp_q[$], input int mode);
    int   t = 0;
    int   d0 = done_cnt;
    logic rd;
    @(negedge clk);
    check("pm_start", 32'(bus.pm_start), 32'd1);
    check("pm_mode", 32'(bus.pm_mode), 32'(mode));
    check("s_ready_busy", 32'(bus.s_ready), 32'd0);
    @(posedge clk); #1;
    bus.pm_busy = 1'b1;
    while (exp_q.size() > 0 && t < 5000) begin
      rd = 1'($urandom_range(0, 1));
      bus.pm_rd_enable = rd;
      @(negedge clk);
      if (rd) begin
        check("pm_valid_in", 32'(bus.pm_valid_in), 32'd1);
        check("pm_din", 32'(bus.pm_din), 32'(exp_q.pop_front()));
      end
      @(posedge clk); #1;
      t++;
    end
    bus.pm_rd_enable = 1'b0;
    bus.pm_busy      = 1'b0;
    wait_done(d0 + 1);
    check("pm_valid_in_empty", 32'(bus.pm_valid_in), 32'd0);
    check("s_ready_after_load", 32'(bus.s_ready), 32'd1);
  endtask

  task automatic run_go();
    logic [DW-1:0] rq[$];
    logic [DW-1:0] none[$];
    int   popped = 0;
    int   occ = 0;
    int   d0 = done_cnt;
    bit   got_last = 1'b0;
    send_frame(16'h0003, none);
    @(negedge clk);
    check("go_pm_start", 32'(bus.pm_start), 32'd1);
    check("go_pm_mode", 32'(bus.pm_mode), 32'd3);
    @(posedge clk); #1;
    bus.pm_busy = 1'b1;
    @(posedge clk); #1;
    fork
      begin
        int sent = 0;
        int t = 0;
        logic [DW-1:0] d;
        while (sent < RS && t < 20000) begin
          if (!bus.pm_fifo_full && $urandom_range(0, 3) != 0) begin
            d = DW'($urandom);
            rq.push_back(d);
            sent++;
            bus.pm_dout      = d;
            bus.pm_wr_enable = 1'b1;
            bus.pm_valid_out = 1'b1;
            bus.pm_done_all  = (sent == RS);
          end else begin
            bus.pm_wr_enable = 1'b0;
            bus.pm_valid_out = 1'b0;
          end
          @(posedge clk); #1;
          t++;
        end
        bus.pm_wr_enable = 1'b0;
        bus.pm_valid_out = 1'b0;
        bus.pm_done_all  = 1'b0;
        bus.pm_busy      = 1'b0;
      end
      begin
        int t = 0;
        while (popped < RS && t < 20000) begin
          bus.m_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          check("pm_fifo_full", 32'(bus.pm_fifo_full), 32'(OUTD - occ <= 2));
          check("m_valid", 32'(bus.m_valid), 32'(occ != 0));
          if (bus.m_valid && bus.m_ready) begin
            popped++;
            check("m_data", 32'(bus.m_data), 32'(rq.pop_front()));
            check("m_last", 32'(bus.m_last), 32'(popped == RS));
            if (bus.m_last) got_last = 1'b1;
            occ--;
          end
          if (bus.pm_wr_enable && bus.pm_valid_out) occ++;
          @(posedge clk); #1;
          t++;
        end
        bus.m_ready = 1'b0;
      end
    join
    check("go_got_last", 32'(got_last), 32'd1);
    wait_done(d0 + 1);
    check("go_err", 32'(err), 32'd0);
    check("go_m_valid_end", 32'(bus.m_valid), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] pay[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] none[$];
    int s0, d0;

    bus.s_valid = 0; bus.s_data = '0; bus.s_last = 0; bus.m_ready = 0;
    bus.pm_busy = 0; bus.pm_done_all = 0; bus.pm_rd_enable = 0;
    bus.pm_valid_out = 0; bus.pm_wr_enable = 0; bus.pm_dout = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("s_ready_pre", 32'(bus.s_ready), 32'd0);
    @(negedge clk);
    check("s_ready_rise", 32'(bus.s_ready), 32'd1);
    @(posedge clk); #1;

    // load A with 0..255
    pay = {};
    for (int i = 0; i < RS; i++) pay.push_back(DW'(i));
    s0 = start_cnt;
    send_frame(16'h0001, pay);
    run_load(pay, 1);
    check("loada_starts", 32'(start_cnt - s0), 32'd1);
    check("loada_err", 32'(err), 32'd0);

    run_go();

    // illegal mode is discarded without starting the multiplier
    pay = {};
    for (int i = 0; i < 3; i++) pay.push_back(DW'($urandom));
    s0 = start_cnt;
    send_frame(16'h0006, pay);
    repeat (3) begin @(posedge clk); #1; end
    check("bad_mode_err", 32'(err), 32'd1);
    check("bad_mode_starts", 32'(start_cnt - s0), 32'd0);
    check("bad_mode_s_ready", 32'(bus.s_ready), 32'd1);

    // load B longer than the input buffer
    pay = {};
    exp_q = {};
    for (int i = 0; i < 300; i++) begin
      pay.push_back(DW'($urandom));
      if (i < IND) exp_q.push_back(pay[i]);
    end
    s0 = start_cnt;
    send_frame(16'h0002, pay);
`ifdef POLY_BRIDGE_LEN_CHECK_EN
    repeat (3) begin @(posedge clk); #1; end
    check("ovf_err", 32'(err), 32'd7);
    check("ovf_starts", 32'(start_cnt - s0), 32'd0);
    check("ovf_flushed", 32'(bus.pm_valid_in), 32'd0);
`else
    run_load(exp_q, 2);
    check("ovf_err", 32'(err), 32'd3);
    check("ovf_starts", 32'(start_cnt - s0), 32'd1);
`endif

    // reset in the middle of a fill
    d0 = done_cnt;
    push_word(16'h0001, 1'b0);
    for (int i = 0; i < 10; i++) push_word(DW'($urandom), 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);

    pay = {};
    for (int i = 0; i < RS; i++) pay.push_back(DW'($urandom));
    s0 = start_cnt;
    send_frame(16'h0001, pay);
    run_load(pay, 1);
    check("post_rst_starts", 32'(start_cnt - s0), 32'd1);
    check("post_rst_err", 32'(err), 32'd0);

    // load header with no payload is a length error
    s0 = start_cnt;
    send_frame(16'h0002, none);
    repeat (3) begin @(posedge clk); #1; end
    check("empty_load_err", 32'(err), 32'd4);
    check("empty_load_starts", 32'(start_cnt - s0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/poly_stream_bridge.md
# poly_stream_bridge

Host-side framing and buffering stage directly upstream and downstream of the polynomial multiplier. It accepts command frames on a valid/ready input stream, buffers each payload completely, then issues the multiplier's start/mode pulse and feeds the buffered words through a first-word-fall-through (FWFT) head. On the return path it captures multiplier results into an output buffer, applies early back-pressure through an almost-full signal, and presents the results as a valid/ready output stream with an end-of-frame marker.

## Interface
- DATA_W, `DATA_SIZE_ARB: payload word width
- RING_SIZE, `RING_SIZE: coefficients per polynomial
- IN_DEPTH, 512: input buffer depth (power of two, at least the twiddle-load length and RING_SIZE)
- OUT_DEPTH, 16: output buffer depth (power of two, at least 4)
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- s_valid / s_ready / s_last  in/out/in  1  host input stream handshake and end-of-frame
- s_data  in  DATA_W  header or payload word
- m_valid / m_ready / m_last  out/in/out  1  host output stream
- m_data  out  DATA_W  result coefficient
- pm_start  out  1  start_transaction pulse
- pm_mode  out  3  mode qualifying pm_start
- pm_busy, pm_done_all  in  1  multiplier status
- pm_valid_in  out  1  input buffer non-empty
- pm_din  out  DATA_W  input buffer head
- pm_rd_enable  in  1  pop input head at this edge
- pm_valid_out, pm_wr_enable  in  1  result qualifier; write pm_dout at this edge
- pm_dout  in  DATA_W  result word
- pm_fifo_full  out  1  almost-full to multiplier
- frame_done  out  1  one-cycle pulse when a frame completes
- err  out  3  sticky errors: [0] illegal mode, [1] overflow, [2] length; cleared by reset only

## Operation
- Frame format: the first word is the header, and header[2:0] is the mode. Modes are 0 (load W), 1 (load A), 2 (load B) and 3 (GO). Remaining words are payload; s_last marks the final word of the frame.
- States:
  - IDLE: s_ready=1. An accepted header latches the mode. If mode≥4, set err[0] and go to DISCARD, or to IDLE if s_last. If mode 0–2 with s_last on the header, set err[2] and go to IDLE. If mode 3 with s_last, go to START. Otherwise go to FILL.
  - FILL: s_ready=1. Each payload word is written to the input buffer. When the buffer is full, the word is dropped and err[1] is set. Go to START on s_last.
  - DISCARD: s_ready=1. Words are dropped until s_last, then go to IDLE.
  - START: pm_start=1 with pm_mode for exactly one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: go to RUN once pm_busy=1.
  - RUN:
    - Modes 0–2: complete when the input buffer is empty and pm_busy=0.
    - Mode 3: go to DRAIN on pm_done_all.
    - On completion (modes 0–2): pulse frame_done, then go to IDLE.
  - DRAIN: go to IDLE with a frame_done pulse on the m_last handshake.
- s_ready=0 in START, WAIT_BUSY, RUN and DRAIN.
- Input buffer: pm_valid_in = !empty and pm_din = head. pm_rd_enable while empty is ignored. The whole payload is buffered before pm_start, so pm_valid_in is never low mid-frame.
- Output buffer: written on pm_wr_enable whenever not full. A write while full is dropped and sets err[1].
  - pm_fifo_full = free slots ≤ 2. The margin absorbs the multiplier's registered write enable.
  - m_valid = !empty.
  - m_last marks the RING_SIZE-th word popped in a GO frame. The counter wraps to 0 after m_last.
- Arithmetic: buffer pointers are log2(depth)+1 bits and wrap modulo 2·depth. Occupancy is the pointer difference.

## Timing
- Reset values:
  - s_ready, m_valid, m_last, pm_start, pm_valid_in, frame_done and err are all 0. s_ready rises on the first cycle after reset.
  - pm_mode, m_data and pm_din are 0.
  - pm_fifo_full is 0.
  - Both buffers are empty and the state is IDLE.
- Reset mid-frame flushes both buffers and aborts the frame. No frame_done is issued.
- Latency:
  - pm_start is asserted in the cycle after the s_last handshake.
  - A pushed input word is visible at pm_din the next cycle.
  - A written result is visible at m_data the next cycle.
- Simultaneous push and pop on the same buffer: both are performed and occupancy is unchanged. A pop on a full buffer frees the slot for the same-cycle push.
- Simultaneous pm_done_all and a final pm_wr_enable: the write is captured before the state transition.

## Configuration
- POLY_BRIDGE_LEN_CHECK_EN
  - Defined: a mode 1/2 payload length ≠ RING_SIZE sets err[2]. The buffer is flushed, no pm_start is issued, and the bridge returns to IDLE.
  - Undefined: any payload length is forwarded unchecked.

## Structure
- Shared package: mode encodings (MODE_LOAD_W, MODE_LOAD_A, MODE_LOAD_B, MODE_GO), state encoding, and err bit indices.
- One sub-module, sync_fifo_fwft (parameters WIDTH, DEPTH; outputs empty, full and occupancy), instantiated once for the input buffer and once for the output buffer.

## Test plan
- Load A frame (header 0x0001 plus 256 words 0..255) → one pm_start with pm_mode=1 after s_last. pm_din presents 0..255 in order, then frame_done.
- GO frame (header 0x0003 with s_last) with a model returning 256 words while m_ready toggles 50% → m_data is identical, m_last on word 256, no err, and pm_fifo_full asserted whenever free slots ≤ 2.
- Header 0x0006 plus 3 words → err[0] set, no pm_start, s_ready stays high.
- Load B with 300 words and IN_DEPTH=256 → err[1] set. With the macro defined, err[2] is also set and no pm_start is issued.
- Reset asserted mid-FILL after 10 words → all outputs return to reset values, and the next valid frame completes normally.
